// File: rtl/slow_memory_cache_if.sv
// CPU load/store port of the slow-memory cache.
interface slow_memory_cache_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_valid;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_valid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_valid, cpu_rdata
    );
endinterface

// File: rtl/slow_memory_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of a
// slow start/rdy memory. One memory transaction in flight at a time.
//
// state | meaning
// IDLE  | accepting CPU requests; load hits answered here
// ISSUE | load miss or store latched; waiting for mem_rdy to pulse mem_start
// WAIT  | memory operation in flight; store data driven onto mem_data
module slow_memory_cache #(
    parameter int NUM_LINES     = 16,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    slow_memory_cache_if.slave       cpu,
    output logic                     mem_start,
    input  logic                     mem_rdy,
    output logic                     mem_write_enable,
    output logic [31:0]              mem_address,
    inout  wire  [31:0]              mem_data,
    output logic [COUNTER_WIDTH-1:0] hit_count,
    output logic [COUNTER_WIDTH-1:0] miss_count
);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [NUM_LINES-1:0]     valid_q, valid_d;
    logic [TAGW-1:0]          tag_q  [NUM_LINES];
    logic [TAGW-1:0]          tag_d  [NUM_LINES];
    logic [31:0]              data_q [NUM_LINES];
    logic [31:0]              data_d [NUM_LINES];
    logic [31:2]              addr_q, addr_d;
    logic                     we_q, we_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     cpu_valid_q, cpu_valid_d;
    logic [31:0]              cpu_rdata_q, cpu_rdata_d;
    logic [COUNTER_WIDTH-1:0] hit_q, hit_d;
    logic [COUNTER_WIDTH-1:0] miss_q, miss_d;

    logic [IDX-1:0]  idx_in, idx_lat;
    logic [TAGW-1:0] tag_in, tag_lat;
    logic            lookup_hit;
    logic            unused_addr_bits;

    // Byte-offset bits of the CPU address carry no information for a word cache.
    assign unused_addr_bits = ^cpu.cpu_addr[1:0];

    assign idx_in     = cpu.cpu_addr[IDX+1:2];
    assign tag_in     = cpu.cpu_addr[31:IDX+2];
    assign idx_lat    = addr_q[IDX+1:2];
    assign tag_lat    = addr_q[31:IDX+2];
    // Hit lookup uses only CPU inputs and cache state, never the memory bus.
    assign lookup_hit = valid_q[idx_in] && (tag_q[idx_in] == tag_in);

    assign cpu.cpu_ready    = (state_q == S_IDLE);
    assign cpu.cpu_valid    = cpu_valid_q;
    assign cpu.cpu_rdata    = cpu_rdata_q;
    assign mem_address      = {addr_q, 2'b00};
    assign mem_write_enable = we_q && (state_q != S_IDLE);
    assign mem_data         = (state_q == S_WAIT && we_q) ? wdata_q : 'z;
    assign hit_count        = hit_q;
    assign miss_count       = miss_q;

    // Next-state, lookup, line fill and counter logic.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        cpu_valid_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        mem_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu.cpu_req) begin
                    addr_d  = cpu.cpu_addr[31:2];
                    we_d    = cpu.cpu_we;
                    wdata_d = cpu.cpu_wdata;
                    if (cpu.cpu_we) begin
                        if (lookup_hit) begin
                            data_d[idx_in] = cpu.cpu_wdata;
                        end
                        state_d = S_ISSUE;
                    end else if (lookup_hit) begin
                        cpu_rdata_d = data_q[idx_in];
                        cpu_valid_d = 1'b1;
                        if (hit_q != '1) hit_d = hit_q + COUNTER_WIDTH'(1);
                    end else begin
                        if (miss_q != '1) miss_d = miss_q + COUNTER_WIDTH'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_rdy) begin
                    mem_start = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rdy) begin
                    if (!we_q) begin
                        cpu_rdata_d      = mem_data;
                        valid_d[idx_lat] = 1'b1;
                        tag_d[idx_lat]   = tag_lat;
                        data_d[idx_lat]  = mem_data;
                    end
                    cpu_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; line tags/data need no reset because valid gates them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        if (!reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end
endmodule

// File: doc/slow_memory_cache.md
Name: slow_memory_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the CPU load/store port and the 5-cycle slow memory.
- Serves read hits in one cycle. Turns read misses and all writes into start/rdy transactions on the slow-memory bus, one transaction at a time.
- Keeps saturating hit/miss counters for performance reporting.

Parameters:
- NUM_LINES, 16, number of one-word (32-bit) lines; power of two, at least 2. IDX = log2(NUM_LINES).
- COUNTER_WIDTH, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- cpu_req  in  1  request strobe; sampled only while cpu_ready=1.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_ready  out  1  1 = controller can accept a request this cycle.
- cpu_valid  out  1  one-cycle pulse: load data on cpu_rdata, or store retired.
- cpu_rdata  out  32  load data; holds its value between pulses.
- mem_start  out  1  one-cycle start pulse to the slow memory.
- mem_rdy  in  1  slow memory idle / operation complete.
- mem_write_enable  out  1  held for the whole transaction.
- mem_address  out  32  {latched addr[31:2], 2'b00}; held for the whole transaction.
- mem_data  inout  32  driven by this block only in the WAIT state of a write; high-Z otherwise.
- hit_count  out  COUNTER_WIDTH  saturating count of load hits.
- miss_count  out  COUNTER_WIDTH  saturating count of load misses.

Behaviour:
- Address split: index = addr[IDX+1:2]; tag = addr[31:IDX+2]. Storage per line: valid, tag, data[31:0].
- Reset (reset=0 at posedge), takes effect even mid-transaction:
  - all valid bits cleared; state = IDLE; both counters = 0.
  - cpu_ready=1, cpu_valid=0, cpu_rdata=0, mem_start=0, mem_write_enable=0, mem_address=0; mem_data released to Z.
  - Any in-flight memory operation is abandoned. The next transaction still waits for mem_rdy=1.
- States:
  - IDLE: cpu_ready=1. On cpu_req=1, latch addr/we/wdata.
    - Load hit (valid && tag match): next cycle cpu_valid=1 and cpu_rdata=line data; hit_count++; stay IDLE. Back-to-back hits give one result per cycle.
    - Load miss: miss_count++; go to ISSUE.
    - Store: on a hit, update line data in the same edge. On a miss, the cache is unchanged. Go to ISSUE.
  - ISSUE: cpu_ready=0. Hold mem_address and mem_write_enable. When mem_rdy=1, assert mem_start for exactly this cycle and go to WAIT. If mem_rdy=0, stay (mem_start=0).
  - WAIT: cpu_ready=0; mem_start=0; address/we held. For a store, drive mem_data=latched wdata. mem_rdy is 0 from the cycle after start. Completion is the first cycle with mem_rdy=1 in WAIT, which is 6 cycles after the mem_start cycle. On completion:
    - Load: capture mem_data into cpu_rdata and fill the line (valid=1, tag, data).
    - Both load and store: pulse cpu_valid next cycle; return to IDLE.
- Latency, request cycle to cpu_valid:
  - load hit: 1 cycle.
  - load miss or any store with memory idle: 8 cycles (1 to ISSUE, start, 6 in flight, +1).
- cpu_req while cpu_ready=0 is ignored (no queueing). The requester must hold or re-present the request.
- Conflict: a load miss to an occupied index overwrites valid, tag and data; no write-back is needed (write-through).
- Counters stop at 2^COUNTER_WIDTH-1. Stores do not count as hits or misses.
- The combinational load-hit path must not depend on mem_* signals.

Test Plan:
- Cold load 0x0000_0010, memory word 0x1122_3344 → mem_start 1 cycle after req; mem_address=0x10, mem_write_enable=0; cpu_valid 8 cycles after req with cpu_rdata=0x11223344; miss_count=1.
- Repeat load 0x10 (and 0x13, low bits ignored) → cpu_valid the next cycle each time, data 0x11223344, no mem_start; hit_count=2.
- Store 0xDEADBEEF to 0x10 (hit) → line updated; mem_data=0xDEADBEEF throughout WAIT; then load 0x10 hits, returning 0xDEADBEEF. Store to 0x20 (miss) → memory written, next load 0x20 misses.
- NUM_LINES=16: load 0x10, then load 0x50 (same index 4, different tag) → both miss; load 0x10 again misses; miss_count=3.
- mem_rdy held 0 for 10 cycles after a miss → stays in ISSUE, mem_start=0; start pulses on the first mem_rdy=1 cycle. A cpu_req during the miss is ignored.
- reset=0 during WAIT of a load miss → next cycle cpu_ready=1, cpu_valid=0, mem_data=Z, counters 0; subsequent load 0x10 misses.
